// File: rtl/interrupt_controller.sv
// Edge-detecting, fixed-priority interrupt controller with a
// request/ack/service/done handshake. Optional: INT_CTRL_LOST_FLAG_EN.
// Ports: clk, rst_n, int_src, int_mask, global_en, irq_ack, irq_done,
//        irq, irq_vector, in_service, pending, [lost_clr, lost].
module interrupt_controller #(
  parameter int INT_NUM      = 4,
  parameter int VECTOR_WIDTH = $clog2(INT_NUM)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [INT_NUM-1:0]      int_src,
  input  logic [INT_NUM-1:0]      int_mask,
  input  logic                    global_en,
  input  logic                    irq_ack,
  input  logic                    irq_done,
  output logic                    irq,
  output logic [VECTOR_WIDTH-1:0] irq_vector,
  output logic                    in_service,
`ifdef INT_CTRL_LOST_FLAG_EN
  output logic [INT_NUM-1:0]      pending,
  input  logic                    lost_clr,
  output logic [INT_NUM-1:0]      lost
`else
  output logic [INT_NUM-1:0]      pending
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    REQUEST = 2'b01,
    SERVICE = 2'b10
  } state_t;

  state_t state, state_n;

  logic [INT_NUM-1:0]      src_d;
  logic [INT_NUM-1:0]      evt;
  logic [INT_NUM-1:0]      clr;
  logic [INT_NUM-1:0]      elig;
  logic [VECTOR_WIDTH-1:0] winner;
  logic                    ack_fire;

  assign evt      = int_src & ~src_d;
  assign elig     = pending & int_mask & {INT_NUM{global_en}};
  assign ack_fire = (state == REQUEST) & irq_ack;
  assign clr      = ack_fire ? (INT_NUM'(1) << irq_vector) : '0;

  // Scan high to low so the lowest eligible index is left in winner.
  always_comb begin
    winner = '0;
    for (int i = INT_NUM - 1; i >= 0; i--) begin
      if (elig[i]) winner = VECTOR_WIDTH'(i);
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (|elig)    state_n = REQUEST;
      REQUEST: if (irq_ack)  state_n = SERVICE;
      SERVICE: if (irq_done) state_n = IDLE;
      default:               state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Ones at reset: a source already high at release is not an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_d      <= '1;
      pending    <= '0;
      irq_vector <= '0;
    end else begin
      src_d   <= int_src;
      pending <= (pending & ~clr) | evt;
      if (state == IDLE && |elig) begin
        irq_vector <= winner;
      end
    end
  end

  assign irq        = (state == REQUEST);
  assign in_service = (state == SERVICE);

`ifdef INT_CTRL_LOST_FLAG_EN
  logic [INT_NUM-1:0] lost_evt;

  assign lost_evt = evt & pending & ~clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lost <= '0;
    end else begin
      lost <= (lost & ~{INT_NUM{lost_clr}}) | lost_evt;
    end
  end
`endif

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed self-checking bench for interrupt_controller.
// Build with +define+INT_CTRL_LOST_FLAG_EN to exercise lost flags.
module tb_interrupt_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] int_src;
  logic [3:0] int_mask;
  logic       global_en;
  logic       irq_ack;
  logic       irq_done;
  logic       irq;
  logic [1:0] irq_vector;
  logic       in_service;
  logic [3:0] pending;
`ifdef INT_CTRL_LOST_FLAG_EN
  logic       lost_clr;
  logic [3:0] lost;
`endif

  int passed = 0;
  int total  = 0;
  logic seen;

  always #5 clk = ~clk;

  interrupt_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .int_src    (int_src),
    .int_mask   (int_mask),
    .global_en  (global_en),
    .irq_ack    (irq_ack),
    .irq_done   (irq_done),
    .irq        (irq),
    .irq_vector (irq_vector),
    .in_service (in_service),
`ifdef INT_CTRL_LOST_FLAG_EN
    .pending    (pending),
    .lost_clr   (lost_clr),
    .lost       (lost)
`else
    .pending    (pending)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    rst_n     = 1'b0;
    int_src   = 4'b0000;
    int_mask  = 4'b1111;
    global_en = 1'b1;
    irq_ack   = 1'b0;
    irq_done  = 1'b0;
`ifdef INT_CTRL_LOST_FLAG_EN
    lost_clr  = 1'b0;
`endif
    step();
    step();
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_vec", 32'(irq_vector), 32'd0);
    chk("rst_insvc", 32'(in_service), 32'd0);
    chk("rst_pend", 32'(pending), 32'd0);
    rst_n = 1'b1;
    step();

    // basic handshake on source 2
    int_src = 4'b0100;
    step();
    chk("b_pend", 32'(pending), 32'h4);
    chk("b_irq_early", 32'(irq), 32'd0);
    step();
    chk("b_irq", 32'(irq), 32'd1);
    chk("b_vec", 32'(irq_vector), 32'd2);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    chk("b_ack_irq", 32'(irq), 32'd0);
    chk("b_ack_insvc", 32'(in_service), 32'd1);
    chk("b_ack_pend", 32'(pending), 32'd0);
    chk("b_svc_vec", 32'(irq_vector), 32'd2);
    irq_done = 1'b1;
    step();
    irq_done = 1'b0;
    chk("b_done_insvc", 32'(in_service), 32'd0);
    chk("b_done_irq", 32'(irq), 32'd0);
    int_src = 4'b0000;
    step();

    // priority: 3 and 1 together
    int_src = 4'b1010;
    step();
    chk("p_pend", 32'(pending), 32'hA);
    step();
    chk("p_irq1", 32'(irq), 32'd1);
    chk("p_vec1", 32'(irq_vector), 32'd1);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    chk("p_pend_after", 32'(pending), 32'h8);
    irq_done = 1'b1;
    step();
    irq_done = 1'b0;
    chk("p_idle_gap", 32'(irq), 32'd0);
    step();
    chk("p_irq3", 32'(irq), 32'd1);
    chk("p_vec3", 32'(irq_vector), 32'd3);
    irq_ack = 1'b1;
    step();
    irq_ack  = 1'b0;
    irq_done = 1'b1;
    step();
    irq_done = 1'b0;
    int_src  = 4'b0000;
    step();

    // mask
    int_mask = 4'b1110;
    int_src  = 4'b0001;
    step();
    step();
    step();
    chk("m_irq_masked", 32'(irq), 32'd0);
    chk("m_pend", 32'(pending), 32'h1);
    int_mask = 4'b1111;
    step();
    chk("m_irq", 32'(irq), 32'd1);
    chk("m_vec", 32'(irq_vector), 32'd0);
    irq_ack = 1'b1;
    step();
    irq_ack  = 1'b0;
    irq_done = 1'b1;
    step();
    irq_done = 1'b0;
    int_src  = 4'b0000;
    step();

    // global enable
    global_en = 1'b0;
    int_src   = 4'b0001;
    step();
    step();
    step();
    chk("g_irq_off", 32'(irq), 32'd0);
    chk("g_pend", 32'(pending), 32'h1);
    global_en = 1'b1;
    step();
    chk("g_irq", 32'(irq), 32'd1);
    chk("g_vec", 32'(irq_vector), 32'd0);
    // request is not withdrawn by disabling in REQUEST
    global_en = 1'b0;
    step();
    chk("g_hold_req", 32'(irq), 32'd1);
    global_en = 1'b1;
    irq_ack   = 1'b1;
    step();
    irq_ack  = 1'b0;
    irq_done = 1'b1;
    step();
    irq_done = 1'b0;
    int_src  = 4'b0000;
    step();

    // ack/done outside their states are ignored
    irq_ack  = 1'b1;
    irq_done = 1'b1;
    step();
    irq_ack  = 1'b0;
    irq_done = 1'b0;
    chk("x_stray_insvc", 32'(in_service), 32'd0);
    chk("x_stray_irq", 32'(irq), 32'd0);

    // level held 300 cycles: one request only
    int_src = 4'b0010;
    step();
    step();
    chk("l_irq", 32'(irq), 32'd1);
    chk("l_vec", 32'(irq_vector), 32'd1);
    irq_ack = 1'b1;
    step();
    irq_ack  = 1'b0;
    irq_done = 1'b1;
    step();
    irq_done = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 296; i++) begin
      step();
      seen = seen | irq | (|pending);
    end
    chk("l_single_req", 32'(seen), 32'd0);
    int_src = 4'b0000;
    step();

    // source high through reset release
    int_src = 4'b0100;
    rst_n   = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    step();
    step();
    chk("r_no_irq", 32'(irq), 32'd0);
    chk("r_no_pend", 32'(pending), 32'd0);
    int_src = 4'b0000;
    step();

    // new edge on 2 coincident with ack of 2
    int_src = 4'b0100;
    step();
    int_src = 4'b0000;
    step();
    chk("s_irq", 32'(irq), 32'd1);
    chk("s_vec", 32'(irq_vector), 32'd2);
    int_src = 4'b0100;
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    chk("s_pend_kept", 32'(pending), 32'h4);
    chk("s_insvc", 32'(in_service), 32'd1);
    irq_done = 1'b1;
    step();
    irq_done = 1'b0;
    chk("s_gap", 32'(irq), 32'd0);
    step();
    chk("s_reirq", 32'(irq), 32'd1);
    chk("s_revec", 32'(irq_vector), 32'd2);
    irq_ack = 1'b1;
    step();
    irq_ack  = 1'b0;
    irq_done = 1'b1;
    step();
    irq_done = 1'b0;
    int_src  = 4'b0000;
    step();

    // two edges on 3 before ack, then reset mid-service
    int_src = 4'b1000;
    step();
    int_src = 4'b0000;
    step();
    chk("z_irq", 32'(irq), 32'd1);
    int_src = 4'b1000;
    step();
`ifdef INT_CTRL_LOST_FLAG_EN
    chk("z_lost", 32'(lost), 32'h8);
    lost_clr = 1'b1;
    step();
    lost_clr = 1'b0;
    chk("z_lost_clr", 32'(lost), 32'h0);
`endif
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    chk("z_insvc", 32'(in_service), 32'd1);
    chk("z_vec", 32'(irq_vector), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("z_rst_insvc", 32'(in_service), 32'd0);
    chk("z_rst_irq", 32'(irq), 32'd0);
    chk("z_rst_vec", 32'(irq_vector), 32'd0);
    chk("z_rst_pend", 32'(pending), 32'd0);
`ifdef INT_CTRL_LOST_FLAG_EN
    chk("z_rst_lost", 32'(lost), 32'd0);
`endif
    step();
    rst_n = 1'b1;
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Collects interrupt requests from the timer interrupt handlers and other peripheral sources, edge-detects and latches them as pending flags, selects one by fixed priority, and presents a single request plus vector to the CPU core. It sits directly downstream of the timer block's `interrupt_request` output and upstream of the core's interrupt entry logic. The handshake is request → acknowledge → service → done, so only one interrupt is in service at a time.

## Interface
Parameters:
- `INT_NUM`, 4, number of interrupt sources; index 0 has the highest priority.
- `VECTOR_WIDTH`, `$clog2(INT_NUM)`, width of `irq_vector`.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `int_src`  in  INT_NUM  source request levels, e.g. timer `interrupt_request`; these may stay high for many cycles.
- `int_mask`  in  INT_NUM  per-source enable; 1 = eligible.
- `global_en`  in  1  global interrupt enable.
- `irq_ack`  in  1  core accepts the current request.
- `irq_done`  in  1  core finished the ISR (return from interrupt).
- `irq`  out  1  request to the core.
- `irq_vector`  out  VECTOR_WIDTH  index of the requested or in-service source.
- `in_service`  out  1  an ISR is active.
- `pending`  out  INT_NUM  latched pending flags (status).
- `lost_clr`  in  1  clear all lost flags (INT_CTRL_LOST_FLAG_EN only).
- `lost`  out  INT_NUM  sticky lost-event flags (INT_CTRL_LOST_FLAG_EN only).

## Operation
- **Edge detect**
  - `src_d` registers `int_src` every cycle.
  - Event on source i = `int_src[i] & ~src_d[i]`.
  - `src_d` resets to all ones, so sources already high at reset release produce no event.
- **Pending**
  - An event sets `pending[i]`, independent of the mask.
  - Acknowledge clears `pending[irq_vector]`.
  - If an event and a clear hit the same bit in the same cycle, set wins.
- **Eligibility**: `pending & int_mask`, gated by `global_en`. The winner is the lowest eligible index.
- **FSM**
  - **IDLE**: if an eligible source exists, latch the winner into `irq_vector` and go to REQUEST.
  - **REQUEST**: `irq` = 1 and `irq_vector` is stable. On `irq_ack`, clear that pending bit and go to SERVICE. A mask or `global_en` change in this state does not withdraw the request.
  - **SERVICE**: `in_service` = 1, `irq` = 0, `irq_vector` holds. On `irq_done`, go to IDLE. New events keep accumulating as pending.
  - `irq_ack` outside REQUEST and `irq_done` outside SERVICE are ignored.
- **Reset values**: FSM = IDLE, `pending` = 0, `irq` = 0, `irq_vector` = 0, `in_service` = 0, `lost` = 0. Reset mid-service abandons the ISR and clears all state.

## Timing
- `int_src` rises before edge N → `pending[i]` = 1 after edge N.
- If IDLE and eligible, `irq` = 1 after edge N+1. Latency from source to `irq` is 2 cycles.
- `irq_ack` sampled at edge M → after M: `irq` = 0, `in_service` = 1, pending bit cleared.
- `irq_done` sampled at edge K → after K: IDLE. If another source is eligible, `irq` = 1 after K+1 (one idle cycle minimum).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `INT_CTRL_LOST_FLAG_EN`.
- **Defined**
  - An event on a source whose pending bit is already 1, and not cleared in that cycle, sets `lost[i]`.
  - `lost` is sticky until `lost_clr`. If `lost_clr` and a new lost event occur together, set wins.
- **Undefined**: the `lost` and `lost_clr` ports are absent and repeated events merge silently into one pending bit.

## Test plan
- **Basic handshake**: `int_src[2]` rises, mask 4'b1111, `global_en` = 1.
  - `irq` = 1 and `irq_vector` = 2 two cycles later.
  - Ack → `irq` = 0, `in_service` = 1, `pending` = 0.
  - Done → IDLE.
- **Priority**: sources 3 and 1 rise in the same cycle → vector 1 first. After ack and done → vector 3.
- **Mask and global enable**
  - Source 0 pending with `int_mask[0]` = 0 → `irq` stays 0 and `pending[0]` = 1.
  - Set mask → `irq` = 1 with vector 0 one cycle later. Repeat with `global_en` toggled.
- **Level hold and reset**: hold `int_src[1]` high for 300 cycles (timer prescaler case) → exactly one request. Hold a source high through reset release → no request.
- **Simultaneous events**: new edge on source 2 in the same cycle as the ack of source 2 → `pending[2]` remains 1, and `irq` re-asserts with vector 2 after the done.
- **Lost flag (INT_CTRL_LOST_FLAG_EN)**
  - Two edges on source 3 before any ack → `lost[3]` = 1.
  - `lost_clr` → `lost` = 0.
  - Assert `rst_n` low during SERVICE → all outputs return to 0 immediately.
